mac_accumulator: RTL and testbench

//  Accumulate stage directly downstream of the 8x8 Wallace-tree multiplier in the NPU MAC unit.

---
 rtl/mac_accumulator.sv | 163 ++++++++++++++++
 tb/tb_mac_accumulator.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// rtl/mac_accumulator.sv - product accumulate stage of the NPU MAC unit (optional clamp: MAC_ACC_SAT_EN)
module mac_accumulator #(
   parameter int ACC_W  = 32,
   parameter int PROD_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clear,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [15:0]      in_product,
   input  logic             in_sign,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [ACC_W-1:0] out_acc,
   output logic             out_overflow,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

   state_t             state;
   logic               rst_done;
   logic               s1_valid;
   logic               s1_last;
   logic               s1_sign;
   logic               s1_first;
   logic [ACC_W-1:0]   s1_ext;
   logic [ACC_W-1:0]   acc;
   logic               ovf_sticky;
   logic               frame_sign;
   logic               in_frame;

   logic [ACC_W-1:0]   ext_in;
   logic               s1_advance;
   logic               in_accept;
   logic               s2_fire;
   logic               frame_signed;
   logic [ACC_W:0]     sum_full;
   logic               ovf_now;
   logic [ACC_W-1:0]   acc_next;

   assign ext_in = in_sign ? {{(ACC_W-PROD_W){in_product[PROD_W-1]}}, in_product}
                           : {{(ACC_W-PROD_W){1'b0}}, in_product};

   // S1 may only hand a last beat to S2 when the result slot can take it
   assign s1_advance   = s1_valid & ~(s1_last & out_valid & ~out_ready);
   assign in_ready     = rst_done & ~clear & (~s1_valid | s1_advance);
   assign in_accept    = in_valid & in_ready;
   assign s2_fire      = s1_valid & s1_advance & ~clear;
   assign frame_signed = s1_first ? s1_sign : frame_sign;
   assign sum_full     = {1'b0, acc} + {1'b0, s1_ext};
   assign ovf_now      = frame_signed
                         ? ((acc[ACC_W-1] == s1_ext[ACC_W-1]) & (sum_full[ACC_W-1] != acc[ACC_W-1]))
                         : sum_full[ACC_W];
   assign busy         = (state != IDLE);

   // Next accumulator value: plain wrap, or clamp-and-hold once the frame has overflowed
   always_comb begin
      acc_next = sum_full[ACC_W-1:0];
`ifdef MAC_ACC_SAT_EN
      if (ovf_sticky) begin
         acc_next = acc;
      end else if (ovf_now) begin
         if (!frame_signed)
            acc_next = {ACC_W{1'b1}};
         else if (acc[ACC_W-1])
            acc_next = {1'b1, {(ACC_W-1){1'b0}}};
         else
            acc_next = {1'b0, {(ACC_W-1){1'b1}}};
      end
`endif
   end

   // Hold in_ready low for the first clock after reset release
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_done <= 1'b0;
      else        rst_done <= 1'b1;
   end

   // Stage 1: register the extended beat, its tag bits and whether it opens a frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_last  <= 1'b0;
         s1_sign  <= 1'b0;
         s1_first <= 1'b0;
         s1_ext   <= '0;
      end else if (clear) begin
         s1_valid <= 1'b0;
      end else if (in_accept) begin
         s1_valid <= 1'b1;
         s1_last  <= in_last;
         s1_sign  <= in_sign;
         s1_first <= ~in_frame;
         s1_ext   <= ext_in;
      end else if (s1_advance) begin
         s1_valid <= 1'b0;
      end
   end

   // Tracks frame boundaries on the input side so S1 knows which beat sets the frame sign
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         in_frame <= 1'b0;
      else if (clear)     in_frame <= 1'b0;
      else if (in_accept) in_frame <= ~in_last;
   end

   // Stage 2: accumulate, collect overflow, restart on the last beat
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc        <= '0;
         ovf_sticky <= 1'b0;
         frame_sign <= 1'b0;
      end else if (clear) begin
         acc        <= '0;
         ovf_sticky <= 1'b0;
      end else if (s2_fire) begin
         frame_sign <= frame_signed;
         if (s1_last) begin
            acc        <= '0;
            ovf_sticky <= 1'b0;
         end else begin
            acc        <= acc_next;
            ovf_sticky <= ovf_sticky | ovf_now;
         end
      end
   end

   // Result slot: load on a retiring last beat, empty on pop or clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid    <= 1'b0;
         out_acc      <= '0;
         out_overflow <= 1'b0;
      end else if (clear) begin
         out_valid <= 1'b0;
      end else if (s2_fire & s1_last) begin
         out_valid    <= 1'b1;
         out_acc      <= acc_next;
         out_overflow <= ovf_sticky | ovf_now;
      end else if (out_valid & out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Frame state: open frame, or last beat waiting for the result slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else if (clear) begin
         state <= IDLE;
      end else if (in_accept & ~in_last) begin
         state <= ACCUM;
      end else if (s1_valid & s1_last & ~s1_advance) begin
         state <= DRAIN;
      end else if (s1_valid & s1_last & s1_advance) begin
         state <= IDLE;
      end
   end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb/tb_mac_accumulator.sv - randomized and directed check of mac_accumulator at ACC_W=32 and ACC_W=17
module tb_mac_accumulator;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        clear = 1'b0;
   logic        in_valid = 1'b0;
   logic [15:0] in_product = '0;
   logic        in_sign = 1'b0;
   logic        in_last = 1'b0;
   logic        out_ready = 1'b0;

   logic        a_in_ready, a_out_valid, a_out_overflow, a_busy;
   logic [31:0] a_out_acc;
   logic        b_in_ready, b_out_valid, b_out_overflow, b_busy;
   logic [16:0] b_out_acc;

   always #5 clk = ~clk;

   mac_accumulator #(.ACC_W(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(a_in_ready), .in_product(in_product),
      .in_sign(in_sign), .in_last(in_last),
      .out_valid(a_out_valid), .out_ready(out_ready), .out_acc(a_out_acc),
      .out_overflow(a_out_overflow), .busy(a_busy)
   );

   mac_accumulator #(.ACC_W(17)) u_dut17 (
      .clk(clk), .rst_n(rst_n), .clear(clear),
      .in_valid(in_valid), .in_ready(b_in_ready), .in_product(in_product),
      .in_sign(in_sign), .in_last(in_last),
      .out_valid(b_out_valid), .out_ready(out_ready), .out_acc(b_out_acc),
      .out_overflow(b_out_overflow), .busy(b_busy)
   );

   typedef struct {logic [15:0] p; bit s;} beat_t;
   typedef struct {longint a32; bit o32; longint a17; bit o17;} exp_t;

   beat_t frame_q[$];
   exp_t  exp_q[$];

   int n_cmp = 0;
   int n_err = 0;

   bit          accepted, rdy_seen, ov_seen, busy_seen, b_ovf_seen;
   logic [31:0] acc_seen;
   logic [16:0] b_acc_seen;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Frame total from plain integer arithmetic on the beats of one frame
   function automatic void model_frame(input int w, output longint total, output bit ovf);
      longint modv, half, acc, e, a_s, e_u, t;
      bit     sticky, fs, o;
      modv   = longint'(1) << w;
      half   = modv >> 1;
      acc    = 0;
      sticky = 0;
      fs     = frame_q[0].s;
      foreach (frame_q[i]) begin
         e   = frame_q[i].s ? longint'($signed(frame_q[i].p)) : longint'(frame_q[i].p);
         a_s = (acc >= half) ? acc - modv : acc;
         e_u = e & (modv - 1);
         if (fs) begin
            t = a_s + e;
            o = (t >= half) || (t < -half);
         end else begin
            t = acc + e_u;
            o = (t >= modv);
         end
`ifdef MAC_ACC_SAT_EN
         if (!sticky) begin
            if (o) acc = fs ? ((t < 0) ? half : half - 1) : modv - 1;
            else   acc = t & (modv - 1);
         end
`else
         acc = t & (modv - 1);
`endif
         sticky = sticky | o;
      end
      total = acc;
      ovf   = sticky;
   endfunction

   // One clock: drive at negedge, sample just after, update the scoreboard
   task automatic cycle(input bit v, input logic [15:0] p, input bit s, input bit l,
                        input bit r, input bit c);
      exp_t  e;
      beat_t b;
      @(negedge clk);
      in_valid = v; in_product = p; in_sign = s; in_last = l; out_ready = r; clear = c;
      #1;
      rdy_seen   = a_in_ready;
      ov_seen    = a_out_valid;
      busy_seen  = a_busy;
      acc_seen   = a_out_acc;
      b_acc_seen = b_out_acc;
      b_ovf_seen = b_out_overflow;
      accepted   = v & a_in_ready;
      if (a_out_valid & r) begin
         check_eq("result_expected", 64'(exp_q.size() > 0), 64'd1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check_eq("acc32", 64'(a_out_acc), 64'(e.a32));
            check_eq("ovf32", 64'(a_out_overflow), 64'(e.o32));
            check_eq("acc17", 64'(b_out_acc), 64'(e.a17));
            check_eq("ovf17", 64'(b_out_overflow), 64'(e.o17));
         end
      end
      if (c) begin
         frame_q.delete();
         exp_q.delete();
      end else if (accepted) begin
         b.p = p;
         b.s = s;
         frame_q.push_back(b);
         if (l) begin
            model_frame(32, e.a32, e.o32);
            model_frame(17, e.a17, e.o17);
            exp_q.push_back(e);
            frame_q.delete();
         end
      end
   endtask

   task automatic send(input logic [15:0] p, input bit s, input bit l, input bit r);
      int n = 0;
      do begin
         cycle(1'b1, p, s, l, r, 1'b0);
         n++;
      end while (!accepted && n < 50);
      check_eq("send_accepted", 64'(accepted), 64'd1);
   endtask

   task automatic idle(input int n, input bit r);
      repeat (n) cycle(1'b0, 16'h0, 1'b0, 1'b0, r, 1'b0);
   endtask

   // Wait (bounded) for a result with out_ready=1 and compare the 32-bit total
   task automatic wait_out(input string tag, input logic [31:0] exp32);
      bit found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         cycle(1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0);
         if (ov_seen) begin
            found = 1;
            check_eq(tag, 64'(acc_seen), 64'(exp32));
         end
      end
      check_eq({tag, "_seen"}, 64'(found), 64'd1);
   endtask

   initial begin
      // reset state
      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_out_valid", 64'(a_out_valid), 64'd0);
      check_eq("rst_out_acc", 64'(a_out_acc), 64'd0);
      check_eq("rst_out_ovf", 64'(a_out_overflow), 64'd0);
      check_eq("rst_busy", 64'(a_busy), 64'd0);
      check_eq("rst_in_ready", 64'(a_in_ready), 64'd0);
      rst_n = 1'b1;
      idle(1, 1'b1);
      check_eq("post_rst_in_ready", 64'(rdy_seen), 64'd1);

      // unsigned frame with exact latency
      for (int i = 0; i < 4; i++) send(16'hFE01, 1'b0, (i == 3), 1'b1);
      idle(1, 1'b1);
      check_eq("lat_t1_valid", 64'(ov_seen), 64'd0);
      idle(1, 1'b1);
      check_eq("lat_t2_valid", 64'(ov_seen), 64'd1);
      check_eq("unsigned_total", 64'(acc_seen), 64'd260100);

      // signed frame
      send(16'hC080, 1'b1, 1'b0, 1'b1);
      send(16'h0001, 1'b1, 1'b1, 1'b1);
      wait_out("signed_total", 32'hFFFFC081);

      // back-pressure: two frames queue up behind a blocked result slot
      send(16'd1, 1'b0, 1'b0, 1'b0);
      send(16'd2, 1'b0, 1'b1, 1'b0);
      send(16'd10, 1'b0, 1'b0, 1'b0);
      send(16'd20, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 16'd5, 1'b0, 1'b1, 1'b0, 1'b0);
         check_eq("bp_in_ready", 64'(rdy_seen), 64'd0);
         check_eq("bp_busy", 64'(busy_seen), 64'd1);
         check_eq("bp_stable", 64'(acc_seen), 64'd3);
      end
      idle(1, 1'b1);
      idle(1, 1'b0);
      check_eq("bp_second_valid", 64'(ov_seen), 64'd1);
      check_eq("bp_second_acc", 64'(acc_seen), 64'd30);
      check_eq("bp_idle_after", 64'(busy_seen), 64'd0);
      idle(1, 1'b1);

      // 17-bit wrap and overflow
      send(16'hFFFF, 1'b0, 1'b0, 1'b1);
      send(16'h0002, 1'b0, 1'b1, 1'b1);
      idle(2, 1'b1);
      send(16'hFFFF, 1'b0, 1'b0, 1'b1);
      send(16'hFFFF, 1'b0, 1'b0, 1'b1);
      send(16'h0001, 1'b0, 1'b0, 1'b1);
      send(16'h0001, 1'b0, 1'b1, 1'b1);
      idle(1, 1'b0);
      idle(1, 1'b0);
      check_eq("ovf17_valid", 64'(ov_seen), 64'd1);
`ifdef MAC_ACC_SAT_EN
      check_eq("ovf17_acc", 64'(b_acc_seen), 64'h1FFFF);
`else
      check_eq("ovf17_acc", 64'(b_acc_seen), 64'h0);
`endif
      check_eq("ovf17_flag", 64'(b_ovf_seen), 64'd1);
      idle(1, 1'b1);

      // clear mid-frame
      for (int i = 0; i < 3; i++) send(16'd100, 1'b0, 1'b0, 1'b1);
      cycle(1'b1, 16'd100, 1'b0, 1'b0, 1'b1, 1'b1);
      check_eq("clear_blocks_ready", 64'(rdy_seen), 64'd0);
      idle(1, 1'b1);
      check_eq("clear_busy", 64'(busy_seen), 64'd0);
      check_eq("clear_out_valid", 64'(ov_seen), 64'd0);
      send(16'd7, 1'b0, 1'b1, 1'b1);
      wait_out("after_clear", 32'd7);

      // back-to-back single-beat frames
      for (int i = 0; i < 8; i++) begin
         send(16'($urandom), 1'($urandom), 1'b1, 1'b1);
         check_eq("b2b_ready", 64'(rdy_seen), 64'd1);
         if (i >= 2) check_eq("b2b_valid", 64'(ov_seen), 64'd1);
      end
      idle(3, 1'b1);

      // asynchronous reset mid-frame with a result held
      send(16'd9, 1'b0, 1'b1, 1'b0);
      idle(2, 1'b0);
      check_eq("pre_rst_acc", 64'(acc_seen), 64'd9);
      send(16'd4, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 64'(a_out_valid), 64'd0);
      check_eq("arst_out_acc", 64'(a_out_acc), 64'd0);
      check_eq("arst_busy", 64'(a_busy), 64'd0);
      check_eq("arst_in_ready", 64'(a_in_ready), 64'd0);
      frame_q.delete();
      exp_q.delete();
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("arst_release_ready", 64'(a_in_ready), 64'd0);
      idle(1, 1'b1);
      check_eq("arst_ready_back", 64'(rdy_seen), 64'd1);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         cycle(1'($urandom_range(0, 3) != 0), 16'($urandom), 1'($urandom),
               1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) < 7),
               1'($urandom_range(0, 59) == 0));
      end
      for (int i = 0; i < 30 && exp_q.size() > 0; i++) idle(1, 1'b1);
      check_eq("drain_empty", 64'(exp_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
